// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state/grant encodings and latency limits for mem_arbiter
package mem_arb_pkg;

    // 2'b11 is unused and steers back to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

    localparam int MEM_LAT_MIN   = 1;
    localparam int MEM_LAT_MAX   = 15;
    localparam int LAT_CNT_WIDTH = 4;

    function automatic logic mem_lat_legal(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_arb_sat_counter.sv
// rtl/mem_arb_sat_counter.sv - saturating event counter with synchronous clear
module mem_arb_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Clear beats increment; the count sticks at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter for one shared memory (option: MEM_ARB_PERF_EN)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef MEM_ARB_PERF_EN
    input  logic                  perf_clr,
    output logic [CNT_WIDTH-1:0]  conflict_cnt,
    output logic [CNT_WIDTH-1:0]  if_stall_cnt,
`endif
    output logic                  busy
);

    if (!mem_lat_legal(MEM_LATENCY) || (CNT_WIDTH < 1)) begin : g_param_check
        $error("mem_arbiter: MEM_LATENCY must be 1..15 and CNT_WIDTH >= 1");
    end

    localparam logic [LAT_CNT_WIDTH-1:0] LAT_LOAD = LAT_CNT_WIDTH'(MEM_LATENCY - 1);

    arb_state_t                state, state_nxt;
    grant_t                    grant, grant_nxt;
    logic                      is_wr, is_wr_nxt;
    logic [LAT_CNT_WIDTH-1:0]  lat_cnt, lat_cnt_nxt;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_nxt;
    logic [DATA_WIDTH-1:0]     if_rdata_q, if_rdata_nxt;
    logic [DATA_WIDTH-1:0]     dm_rdata_q, dm_rdata_nxt;

    // State, grant history, latched access and per-port read data registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= GNT_DM;
            is_wr      <= 1'b0;
            lat_cnt    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            is_wr      <= is_wr_nxt;
            lat_cnt    <= lat_cnt_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            if_rdata_q <= if_rdata_nxt;
            dm_rdata_q <= dm_rdata_nxt;
        end
    end

    // Next-state: pick a port in IDLE, time the access, capture read data on its last cycle.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        is_wr_nxt    = is_wr;
        lat_cnt_nxt  = lat_cnt;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        if_rdata_nxt = if_rdata_q;
        dm_rdata_nxt = dm_rdata_q;
        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    if (if_req && dm_req) begin
                        grant_nxt = (grant == GNT_DM) ? GNT_IF : GNT_DM;
                    end else begin
                        grant_nxt = if_req ? GNT_IF : GNT_DM;
                    end
                    if (grant_nxt == GNT_IF) begin
                        addr_nxt  = if_addr;
                        is_wr_nxt = 1'b0;
                    end else begin
                        addr_nxt  = dm_addr;
                        wdata_nxt = dm_wdata;
                        is_wr_nxt = dm_we;
                    end
                    lat_cnt_nxt = LAT_LOAD;
                    state_nxt   = ACCESS;
                end
            end
            ACCESS: begin
                if (is_wr) begin
                    state_nxt = RESP;
                end else if (lat_cnt == '0) begin
                    if (grant == GNT_IF) begin
                        if_rdata_nxt = mem_rdata;
                    end else begin
                        dm_rdata_nxt = mem_rdata;
                    end
                    state_nxt = RESP;
                end else begin
                    lat_cnt_nxt = lat_cnt - 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes and acks decode straight from state so reset silences them at once.
    assign mem_read  = (state == ACCESS) && !is_wr;
    assign mem_write = (state == ACCESS) && is_wr;
    assign if_ack    = (state == RESP) && (grant == GNT_IF);
    assign dm_ack    = (state == RESP) && (grant == GNT_DM);
    assign busy      = (state != IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

`ifdef MEM_ARB_PERF_EN
    mem_arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_conflict_cnt (
        .clock (clock),
        .reset (reset),
        .inc   ((state == IDLE) && if_req && dm_req),
        .clr   (perf_clr),
        .count (conflict_cnt)
    );

    mem_arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_if_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (if_req && !if_ack),
        .clr   (perf_clr),
        .count (if_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at latencies 1 and 3
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        logic          if_req = 1'b0;
        logic [AW-1:0] if_addr = '0;
        logic [DW-1:0] if_rdata;
        logic          if_ack;
        logic          dm_req = 1'b0;
        logic          dm_we = 1'b0;
        logic [AW-1:0] dm_addr = '0;
        logic [DW-1:0] dm_wdata = '0;
        logic [DW-1:0] dm_rdata;
        logic          dm_ack;
        logic [AW-1:0] mem_addr;
        logic          mem_read;
        logic          mem_write;
        logic [DW-1:0] mem_wdata;
        logic [DW-1:0] mem_rdata;
        logic          busy;
`ifdef MEM_ARB_PERF_EN
        logic          perf_clr = 1'b0;
        logic [CW-1:0] conflict_cnt;
        logic [CW-1:0] if_stall_cnt;
`endif

        mem_arbiter #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .MEM_LATENCY(LAT),
            .CNT_WIDTH  (CW)
        ) u_dut (
            .clock    (clock),
            .reset    (reset),
            .if_req   (if_req),
            .if_addr  (if_addr),
            .if_rdata (if_rdata),
            .if_ack   (if_ack),
            .dm_req   (dm_req),
            .dm_we    (dm_we),
            .dm_addr  (dm_addr),
            .dm_wdata (dm_wdata),
            .dm_rdata (dm_rdata),
            .dm_ack   (dm_ack),
            .mem_addr (mem_addr),
            .mem_read (mem_read),
            .mem_write(mem_write),
            .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata),
`ifdef MEM_ARB_PERF_EN
            .perf_clr    (perf_clr),
            .conflict_cnt(conflict_cnt),
            .if_stall_cnt(if_stall_cnt),
`endif
            .busy     (busy)
        );

        // Memory environment: storage plus reference copy; fetch uses words 0..15, data 16..31.
        logic [DW-1:0] phys [32];
        logic [DW-1:0] refm [32];
        int            rd_run = 0;
        int            wr_run = 0;
        logic [AW-1:0] last_rd_addr = '0;

        // Data is only valid once the read has been held LAT cycles; before that it is garbage.
        assign mem_rdata = (rd_run >= LAT) ? phys[mem_addr[4:0]] : ~phys[mem_addr[4:0]];

        // Memory side: commit writes, measure strobe run lengths.
        always @(negedge clock) begin
            if (!reset) begin
                rd_run = 0;
                wr_run = 0;
            end else begin
                if (mem_read && mem_write) check("strobe_exclusive", 1, 0);
                if (mem_read) begin
                    rd_run++;
                    last_rd_addr = mem_addr;
                end else if (rd_run != 0) begin
                    check("read_strobe_len", rd_run, LAT);
                    rd_run = 0;
                end
                if (mem_write) begin
                    wr_run++;
                    phys[mem_addr[4:0]] = mem_wdata;
                end else if (wr_run != 0) begin
                    check("write_strobe_len", wr_run, 1);
                    wr_run = 0;
                end
            end
        end

        logic [DW-1:0] exp_if [$];
        logic [DW-1:0] exp_dm_d [$];
        logic          exp_dm_we [$];
        logic [DW-1:0] model_dm_rd = '0;
        int            last_if_cyc = 0;
        int            last_dm_cyc = 0;

        // Monitor: pop the expected response whenever a port is acknowledged.
        always @(negedge clock) begin
            logic [DW-1:0] d;
            logic          w;
            if (!reset) begin
                model_dm_rd = '0;
            end else begin
                if (if_ack && dm_ack) check("dual_ack", 1, 0);
                if (if_ack) begin
                    last_if_cyc = cyc;
                    if (exp_if.size() == 0) check("if_spurious_ack", 1, 0);
                    else check("if_rdata", if_rdata, exp_if.pop_front());
                end
                if (dm_ack) begin
                    last_dm_cyc = cyc;
                    if (exp_dm_d.size() == 0) begin
                        check("dm_spurious_ack", 1, 0);
                    end else begin
                        d = exp_dm_d.pop_front();
                        w = exp_dm_we.pop_front();
                        if (!w) model_dm_rd = d;
                        check(w ? "dm_rdata_hold" : "dm_rdata", dm_rdata, model_dm_rd);
                    end
                end
            end
        end

        task automatic init_mem();
            logic [DW-1:0] v;
            for (int i = 0; i < 32; i++) begin
                v = $urandom;
                phys[i] = v;
                refm[i] = v;
            end
            phys[4] = 32'h8C22_0000;
            refm[4] = 32'h8C22_0000;
        endtask

        task automatic check_idle(input string tag);
            check({tag, "_strobes"}, {mem_read, mem_write, if_ack, dm_ack, busy}, 0);
            check({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 0);
            check({tag, "_rdata"}, {if_rdata, dm_rdata}, 0);
        endtask

        task automatic if_read(input logic [4:0] a, output int lat_o);
            int start;
            int n;
            exp_if.push_back(refm[a]);
            if_addr = {27'd0, a};
            if_req  = 1'b1;
            start   = cyc;
            n       = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!if_ack && n < 200);
            if (!if_ack) check("if_ack_timeout", 0, 1);
            lat_o = cyc - start;
            @(posedge clock);
            #1 if_req = 1'b0;
        endtask

        task automatic dm_access(input logic we, input logic [4:0] a, input logic [DW-1:0] d,
                                 output int lat_o);
            int start;
            int n;
            if (we) refm[a] = d;
            exp_dm_we.push_back(we);
            exp_dm_d.push_back(refm[a]);
            dm_we    = we;
            dm_addr  = {27'd0, a};
            dm_wdata = d;
            dm_req   = 1'b1;
            start    = cyc;
            n        = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!dm_ack && n < 200);
            if (!dm_ack) check("dm_ack_timeout", 0, 1);
            lat_o = cyc - start;
            @(posedge clock);
            #1 dm_req = 1'b0;
        endtask

        task automatic if_random(input int n);
            int lat;
            repeat (n) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clock);
                    #1;
                end
                if_read(5'($urandom_range(0, 15)), lat);
            end
        endtask

        task automatic dm_random(input int n);
            int lat;
            repeat (n) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clock);
                    #1;
                end
                dm_access(1'($urandom_range(0, 1)), 5'($urandom_range(16, 31)), $urandom, lat);
            end
        endtask

        task automatic final_checks();
            check("if_queue_drained", exp_if.size(), 0);
            check("dm_queue_drained", exp_dm_d.size(), 0);
        endtask
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int lat_a;
        int lat_b;
        g_dut[0].init_mem();
        g_dut[1].init_mem();
        repeat (3) @(posedge clock);
        @(negedge clock);
        g_dut[0].check_idle("reset_l1");
        g_dut[1].check_idle("reset_l3");
        @(posedge clock);
        #1 reset = 1'b1;

        // Latency-1 fetch of word 4.
        g_dut[0].if_read(5'd4, lat);
        check("t1_if_latency", lat, 2);
        check("t1_mem_addr", g_dut[0].last_rd_addr, 32'h4);
        check("t1_if_rdata_held", g_dut[0].if_rdata, 32'h8C22_0000);

        // Write then read back through the data port.
        g_dut[0].dm_access(1'b1, 5'h10, 32'hDEAD_BEEF, lat);
        check("t2_write_latency", lat, 2);
        g_dut[0].dm_access(1'b0, 5'h10, '0, lat);
        check("t2_read_latency", lat, 2);
        check("t2_dm_rdata", g_dut[0].dm_rdata, 32'hDEAD_BEEF);

        // Simultaneous requests right after reset: fetch wins, data follows one slot later.
        fork
            g_dut[1].if_read(5'd7, lat_a);
            g_dut[1].dm_access(1'b0, 5'd20, '0, lat_b);
        join
        check("t3_if_first_latency", lat_a, 4);
        check("t3_dm_after_if", g_dut[1].last_dm_cyc - g_dut[1].last_if_cyc, 5);

        // Latency-3 reads on both ports.
        g_dut[1].if_read(5'd9, lat);
        check("t4_if_latency", lat, 4);
        g_dut[1].dm_access(1'b1, 5'd21, 32'h1234_5678, lat);
        check("t4_write_latency", lat, 2);
        g_dut[1].dm_access(1'b0, 5'd21, '0, lat);
        check("t4_dm_latency", lat, 4);

        // Reset in the second ACCESS cycle of a latency-3 read.
        g_dut[1].if_addr = 32'd3;
        g_dut[1].if_req  = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        g_dut[1].check_idle("t5_abort");
        g_dut[1].if_req = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        g_dut[1].if_read(5'd3, lat);
        check("t5_recover_latency", lat, 4);
        g_dut[0].dm_access(1'b0, 5'h10, '0, lat);
        check("t5_l1_after_reset", lat, 2);

        // Random traffic on both ports of both instances.
        fork
            g_dut[0].if_random(40);
            g_dut[0].dm_random(40);
            g_dut[1].if_random(30);
            g_dut[1].dm_random(30);
        join

`ifdef MEM_ARB_PERF_EN
        g_dut[0].perf_clr = 1'b1;
        @(posedge clock);
        #1 g_dut[0].perf_clr = 1'b0;
        check("t6_conflict_cleared", g_dut[0].conflict_cnt, 0);
        repeat (5) begin
            fork
                g_dut[0].if_read(5'($urandom_range(0, 15)), lat_a);
                g_dut[0].dm_access(1'b0, 5'($urandom_range(16, 31)), '0, lat_b);
            join
        end
        check("t6_conflict_saturated", g_dut[0].conflict_cnt, 3);
        check("t6_stall_saturated", g_dut[0].if_stall_cnt, 3);
        g_dut[0].perf_clr = 1'b1;
        @(posedge clock);
        #1 g_dut[0].perf_clr = 1'b0;
        check("t6_conflict_clr", g_dut[0].conflict_cnt, 0);
        check("t6_stall_clr", g_dut[0].if_stall_cnt, 0);
`endif

        repeat (4) @(posedge clock);
        g_dut[0].final_checks();
        g_dut[1].final_checks();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
